// File: rtl/reception_checker.sv
// Read-side stream checker: pops an FWFT FIFO, compares each word against the
// (k*step) mod 2^w transmit pattern, captures words and keeps mismatch statistics.
module reception_checker #(
    parameter  int w       = 8,
    parameter  int n_words = 128,
    parameter  int step    = 2,
    localparam int AW      = $clog2(n_words)
) (
    input  logic          read_clk,
    input  logic          reset,
    input  logic          start,
    input  logic          hold,
    input  logic [w-1:0]  fifo_data,
    input  logic          fifo_empty,
    output logic          fifo_rd_en,
    output logic          busy,
    output logic          done,
    output logic [7:0]    rx_count,
    output logic [7:0]    err_count,
    output logic          err_flag,
    output logic [7:0]    first_idx,
    output logic [w-1:0]  first_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [w-1:0]  dbg_data
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [7:0] LAST_IDX = 8'(n_words - 1);

    state_t         state_q, state_d;
    logic [7:0]     rx_count_q, rx_count_d;
    logic [7:0]     err_count_q, err_count_d;
    logic           err_flag_q, err_flag_d;
    logic [7:0]     first_idx_q, first_idx_d;
    logic [w-1:0]   first_data_q, first_data_d;
    logic [w-1:0]   expected_q, expected_d;
    logic [w-1:0]   dbg_data_q;
    logic [w-1:0]   cap_mem [n_words];
    logic           mismatch;

    // Reset and start both block the pop so a restart never consumes a word.
    assign fifo_rd_en = (state_q == RUN) && !fifo_empty && !hold && !start && !reset;
    assign mismatch   = (fifo_data != expected_q);

    always_comb begin
        state_d      = state_q;
        rx_count_d   = rx_count_q;
        err_count_d  = err_count_q;
        err_flag_d   = err_flag_q;
        first_idx_d  = first_idx_q;
        first_data_d = first_data_q;
        expected_d   = expected_q;

        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN: begin
                if (start) begin
                    state_d = RUN;
                end else if (fifo_rd_en && (rx_count_q == LAST_IDX)) begin
                    state_d = DONE;
                end
            end
            DONE:    if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase

        if (start) begin
            rx_count_d   = '0;
            err_count_d  = '0;
            err_flag_d   = 1'b0;
            first_idx_d  = '0;
            first_data_d = '0;
            expected_d   = '0;
        end else if (fifo_rd_en) begin
            rx_count_d = rx_count_q + 8'd1;
            expected_d = expected_q + w'(step);
            if (mismatch) begin
                if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
                err_flag_d = 1'b1;
                if (!err_flag_q) begin
                    first_idx_d  = rx_count_q;
                    first_data_d = fifo_data;
                end
            end
        end
    end

    always_ff @(posedge read_clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rx_count_q   <= '0;
            err_count_q  <= '0;
            err_flag_q   <= 1'b0;
            first_idx_q  <= '0;
            first_data_q <= '0;
            expected_q   <= '0;
        end else begin
            state_q      <= state_d;
            rx_count_q   <= rx_count_d;
            err_count_q  <= err_count_d;
            err_flag_q   <= err_flag_d;
            first_idx_q  <= first_idx_d;
            first_data_q <= first_data_d;
            expected_q   <= expected_d;
        end
    end

    // Capture buffer keeps its contents across reset so it can be inspected afterwards.
    always_ff @(posedge read_clk) begin
        if (fifo_rd_en) cap_mem[rx_count_q[AW-1:0]] <= fifo_data;
    end

    always_ff @(posedge read_clk) begin
        if (reset) dbg_data_q <= '0;
        else       dbg_data_q <= cap_mem[dbg_addr];
    end

    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign rx_count   = rx_count_q;
    assign err_count  = err_count_q;
    assign err_flag   = err_flag_q;
    assign first_idx  = first_idx_q;
    assign first_data = first_data_q;
    assign dbg_data   = dbg_data_q;

endmodule

// File: tb/tb_reception_checker.sv
// Directed bench for reception_checker: a 128-word build for the main scenarios
// and a 256-word build for error-count saturation.
module tb_reception_checker;

    logic       read_clk = 1'b0;
    logic       reset, start, start2, hold, fifo_empty;
    logic [7:0] fifo_data;
    logic [6:0] dbg_addr;
    logic [7:0] dbg_addr2;

    logic       rd_en, busy, done, err_flag;
    logic [7:0] rx_count, err_count, first_idx, first_data, dbg_data;
    logic       rd_en2, busy2, done2, err_flag2;
    logic [7:0] rx_count2, err_count2, first_idx2, first_data2, dbg_data2;

    int  compared   = 0;
    int  mismatched = 0;
    int  head       = 0;
    int  corrupt_idx = -1;
    logic [7:0] corrupt_val = 8'h00;
    bit  all_wrong  = 0;
    bit  use256     = 0;
    int  guard_viol = 0;

    always #5 read_clk = ~read_clk;

    reception_checker #(.w(8), .n_words(128), .step(2)) dut (
        .read_clk(read_clk), .reset(reset), .start(start), .hold(hold),
        .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd_en(rd_en),
        .busy(busy), .done(done), .rx_count(rx_count), .err_count(err_count),
        .err_flag(err_flag), .first_idx(first_idx), .first_data(first_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    reception_checker #(.w(8), .n_words(256), .step(2)) dut256 (
        .read_clk(read_clk), .reset(reset), .start(start2), .hold(hold),
        .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd_en(rd_en2),
        .busy(busy2), .done(done2), .rx_count(rx_count2), .err_count(err_count2),
        .err_flag(err_flag2), .first_idx(first_idx2), .first_data(first_data2),
        .dbg_addr(dbg_addr2), .dbg_data(dbg_data2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    function automatic logic [7:0] word_of(input int k);
        logic [7:0] v;
        v = 8'((k * 2) % 256);
        if (all_wrong) v = ~v;
        if (k == corrupt_idx) v = corrupt_val;
        return v;
    endfunction

    // Called at a falling edge; presents the FIFO head and advances it on a pop.
    task automatic drive_cycle(input bit h, input bit e);
        bit popped;
        hold       = h;
        fifo_empty = e;
        fifo_data  = word_of(head);
        #1;
        popped = use256 ? rd_en2 : rd_en;
        if (popped && (h || e)) guard_viol++;
        @(posedge read_clk);
        if (popped) head++;
        @(negedge read_clk);
    endtask

    task automatic do_start(input bit reset_head, output bit rd_seen);
        if (reset_head) head = 0;
        hold       = 1'b0;
        fifo_empty = 1'b0;
        fifo_data  = word_of(head);
        if (use256) start2 = 1'b1;
        else        start  = 1'b1;
        #1;
        rd_seen = use256 ? rd_en2 : rd_en;
        @(posedge read_clk);
        @(negedge read_clk);
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    initial begin
        bit rd_seen;
        int cyc;
        int head_before;

        reset = 1'b1; start = 1'b0; start2 = 1'b0; hold = 1'b0;
        fifo_empty = 1'b1; fifo_data = 8'h00; dbg_addr = '0; dbg_addr2 = '0;
        repeat (2) @(posedge read_clk);
        @(negedge read_clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rx_count", rx_count, 0);
        check("rst_err_count", err_count, 0);
        check("rst_dbg_data", dbg_data, 0);
        reset = 1'b0;

        // Continuous clean stream: one pop per cycle, done after exactly 128 cycles.
        do_start(1, rd_seen);
        check("t1_busy_after_start", busy, 1);
        repeat (127) drive_cycle(0, 0);
        check("t1_rx_at_127", rx_count, 127);
        check("t1_not_done_at_127", done, 0);
        drive_cycle(0, 0);
        check("t1_done", done, 1);
        check("t1_busy_clear", busy, 0);
        check("t1_rx_count", rx_count, 128);
        check("t1_err_count", err_count, 0);
        check("t1_err_flag", err_flag, 0);
        dbg_addr = 7'd5;
        @(posedge read_clk); @(negedge read_clk);
        check("t1_dbg_5", dbg_data, 8'd10);

        // Single corrupted word at index 3.
        corrupt_idx = 3; corrupt_val = 8'h07;
        do_start(1, rd_seen);
        check("t2_done_cleared", done, 0);
        repeat (128) drive_cycle(0, 0);
        check("t2_done", done, 1);
        check("t2_err_count", err_count, 1);
        check("t2_err_flag", err_flag, 1);
        check("t2_first_idx", first_idx, 3);
        check("t2_first_data", first_data, 8'h07);
        corrupt_idx = -1;

        // Backpressure: hold every other cycle, random empty.
        guard_viol = 0;
        do_start(1, rd_seen);
        cyc = 0;
        while (!done && cyc < 2000) begin
            drive_cycle(cyc[0], $urandom_range(0, 2) == 0);
            cyc++;
        end
        check("t3_done", done, 1);
        check("t3_guard", guard_viol, 0);
        check("t3_rx_count", rx_count, 128);
        check("t3_err_count", err_count, 0);
        check("t3_fifo_head", head, 128);
        dbg_addr = 7'd100;
        @(posedge read_clk); @(negedge read_clk);
        check("t3_dbg_100", dbg_data, 8'd200);
        dbg_addr = 7'd127;
        @(posedge read_clk); @(negedge read_clk);
        check("t3_dbg_127", dbg_data, 8'd254);

        // Every word wrong, then a restart must clear the statistics.
        all_wrong = 1;
        do_start(1, rd_seen);
        repeat (128) drive_cycle(0, 0);
        check("t4_err_count", err_count, 128);
        check("t4_first_idx", first_idx, 0);
        check("t4_first_data", first_data, 8'hFF);
        all_wrong = 0;
        do_start(1, rd_seen);
        check("t4_restart_err_count", err_count, 0);
        check("t4_restart_err_flag", err_flag, 0);
        check("t4_restart_busy", busy, 1);
        check("t4_restart_done", done, 0);

        // Restart mid-run at rx_count=40; FIFO keeps its position.
        repeat (40) drive_cycle(0, 0);
        check("t5_rx_at_40", rx_count, 40);
        do_start(0, rd_seen);
        check("t5_no_pop_on_start", rd_seen, 0);
        check("t5_rx_cleared", rx_count, 0);
        check("t5_busy", busy, 1);
        drive_cycle(0, 0);
        check("t5_err_count", err_count, 1);
        check("t5_first_idx", first_idx, 0);
        check("t5_first_data", first_data, 8'd80);

        // Reset mid-run at rx_count=60.
        repeat (59) drive_cycle(0, 0);
        check("t6_rx_at_60", rx_count, 60);
        reset = 1'b1; hold = 1'b0; fifo_empty = 1'b0; fifo_data = word_of(head);
        #1;
        check("t6_no_pop_in_reset", rd_en, 0);
        @(posedge read_clk); @(negedge read_clk);
        reset = 1'b0;
        check("t6_busy", busy, 0);
        check("t6_rx_count", rx_count, 0);
        check("t6_done", done, 0);
        head_before = head;
        repeat (4) drive_cycle(0, 0);
        check("t6_no_pops_idle", head, head_before);

        // 256-word build: 256 mismatches saturate the error counter at 255.
        use256 = 1; all_wrong = 1;
        do_start(1, rd_seen);
        repeat (255) drive_cycle(0, 0);
        check("t7_rx_at_255", rx_count2, 255);
        check("t7_err_at_255", err_count2, 255);
        check("t7_not_done", done2, 0);
        drive_cycle(0, 0);
        check("t7_err_saturated", err_count2, 255);
        check("t7_rx_wrapped", rx_count2, 0);
        check("t7_done", done2, 1);
        check("t7_err_flag", err_flag2, 1);
        check("t7_first_data", first_data2, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
